// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift-register sequencer: FSM states and fill modes.
package shift_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      FILL_ZERO = 2'b00,
      FILL_ONE  = 2'b01,
      FILL_ROT  = 2'b10,
      FILL_RSVD = 2'b11
   } fill_e;

   localparam int N_DEFAULT  = 8;
   localparam int CW_DEFAULT = 4;

endpackage

// File: rtl/shift_seq_ctrl_cnt.sv
// Loadable down counter holding the remaining shift count, with ==1 / ==0 flags.
module shift_cnt #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          cnt_is_one,
   output logic          cnt_is_zero
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_is_one  = (cnt_q == CW'(1));
   assign cnt_is_zero = (cnt_q == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an N-bit load/shift register: one load cycle, then amount shift cycles.
//   state | meaning
//   IDLE  | waiting for start; all outputs low
//   LOAD  | ld strobe; counter holds the clamped shift count
//   SHIFT | shift_en strobe; counter steps down to 1
//   DONE  | one-cycle done pulse, then back to IDLE
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          dir,
   input  logic [CW-1:0] amount,
   input  logic [1:0]    mode,
   input  logic          abort,
   input  logic          reg_msb,
   input  logic          reg_lsb,
   output logic          ld,
   output logic          shift_en,
   output logic          shift_type,
   output logic          ser_in,
   output logic          busy,
   output logic          done
);

   localparam logic [CW-1:0] N_CW = CW'(N);

   state_e state_q, state_d;
   logic   dir_q, dir_d;
   fill_e  mode_q, mode_d;
   logic   ld_q, ld_d;
   logic   shift_en_q, shift_en_d;
   logic   shift_type_q, shift_type_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;

   logic          cnt_load;
   logic          cnt_dec;
   logic          cnt_is_one;
   logic          cnt_is_zero;
   logic [CW-1:0] amt_eff;

   assign amt_eff = (amount > N_CW) ? N_CW : amount;

   shift_cnt #(.CW(CW)) u_cnt (
      .clk         (clk),
      .rst_n       (rst),
      .load        (cnt_load),
      .load_val    (amt_eff),
      .dec         (cnt_dec),
      .cnt_is_one  (cnt_is_one),
      .cnt_is_zero (cnt_is_zero)
   );

   // Counter is loaded on the accept edge so LOAD can already see a zero count.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      mode_d   = mode_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d  = ST_LOAD;
               dir_d    = dir;
               mode_d   = fill_e'(mode);
               cnt_load = 1'b1;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cnt_is_zero) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               cnt_dec = 1'b1;
               if (cnt_is_one) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ld_d         = (state_d == ST_LOAD);
      shift_en_d   = (state_d == ST_SHIFT);
      done_d       = (state_d == ST_DONE);
      busy_d       = (state_d != ST_IDLE);
      shift_type_d = (state_d != ST_IDLE) && dir_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         dir_q        <= 1'b0;
         mode_q       <= FILL_ZERO;
         ld_q         <= 1'b0;
         shift_en_q   <= 1'b0;
         shift_type_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         mode_q       <= mode_d;
         ld_q         <= ld_d;
         shift_en_q   <= shift_en_d;
         shift_type_q <= shift_type_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Rotate feeds back the bit about to fall off the far end of the register.
   always_comb begin
      ser_in = 1'b0;
      if (state_q == ST_SHIFT) begin
         unique case (mode_q)
            FILL_ONE: ser_in = 1'b1;
            FILL_ROT: ser_in = dir_q ? reg_msb : reg_lsb;
            default:  ser_in = 1'b0;
         endcase
      end
   end

   assign ld         = ld_q;
   assign shift_en   = shift_en_q;
   assign shift_type = shift_type_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
